cla_sub_serial: RTL and testbench



---
 rtl/cla_pkg.sv | 19 +
 rtl/borrow_lookahead_4bit.sv | 40 ++++
 rtl/cla_sub_serial.sv | 151 +++++++++++++++
 tb/tb_cla_sub_serial.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the serial borrow-lookahead subtractor.
//   SLICE_W : bits handled per clock by the lookahead slice
//   state_e : control FSM states
//   nslice(): number of slices needed for a given operand width
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/borrow_lookahead_4bit.sv
// 4-bit borrow-lookahead subtract slice: d = a - b - bin.
//   a, b    : 4-bit operands
//   bin     : borrow into bit 0
//   d       : 4-bit difference
//   bout    : borrow out of bit 3
//   bmsb_in : borrow into bit 3 (for signed overflow)
// Every internal borrow is a flat sum of products of g/p/bin.
// No borrow ripples from bit to bit.
module borrow_lookahead_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout,
    output logic       bmsb_in
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] br;

    // A bit generates a borrow when it is 0 - 1.
    // It passes an incoming borrow through when a == b.
    assign g = ~a & b;
    assign p = ~(a ^ b);

    assign br[0] = bin;
    assign br[1] = g[0] | (p[0] & bin);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & bin);
    assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d       = a ^ b ^ br[3:0];
    assign bout    = br[4];
    assign bmsb_in = br[3];

endmodule

// File: rtl/cla_sub_serial.sv
// Multi-cycle unsigned subtractor.
// It computes diff = a - b - bin (mod 2^WIDTH), one 4-bit slice per clock.
// The borrow is carried between slices in a register.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (a, b, bin)
//   out_valid / out_ready: result handshake (diff, bout)
//   zero, ovf            : registered result flags. These are present only when
//                          CLA_SUB_FLAGS_EN is defined.
// Flow: IDLE accepts operands. RUN spends one cycle per slice.
// DONE holds the result until it is consumed.
import cla_pkg::*;

module cla_sub_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef CLA_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int SH     = $clog2(SLICE_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             br_q, br_d;
`ifdef CLA_SUB_FLAGS_EN
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
`endif

    // Bit offset of the active slice.
    logic [IDX_W+SH-1:0] base;
    logic [SLICE_W-1:0]  sl_a, sl_b, sl_d;
    logic                sl_bout, sl_bmsb;

    assign base = {idx_q, {SH{1'b0}}};
    assign sl_a = a_q[base +: SLICE_W];
    assign sl_b = b_q[base +: SLICE_W];

    // A single slice serves every bit position. The operand slice is muxed by idx.
    borrow_lookahead_4bit u_slice (
        .a       (sl_a),
        .b       (sl_b),
        .bin     (br_q),
        .d       (sl_d),
        .bout    (sl_bout),
        .bmsb_in (sl_bmsb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        br_d    = br_q;
`ifdef CLA_SUB_FLAGS_EN
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    idx_d   = '0;
                    res_d   = '0;
`ifdef CLA_SUB_FLAGS_EN
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[base +: SLICE_W] = sl_d;
                br_d = sl_bout;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
`ifdef CLA_SUB_FLAGS_EN
                    // res_d now holds the complete difference.
                    zero_d  = (res_d == '0);
                    ovf_d   = sl_bmsb ^ sl_bout;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            br_q    <= 1'b0;
`ifdef CLA_SUB_FLAGS_EN
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            br_q    <= br_d;
`ifdef CLA_SUB_FLAGS_EN
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = res_q;
    assign bout      = br_q;
`ifdef CLA_SUB_FLAGS_EN
    assign zero      = zero_q;
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_sub_serial.sv
module tb_cla_sub_serial;

    localparam int WIDTH  = 16;
    localparam int NSLICE = 4;

    logic        clk, rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout;
    logic [15:0] a, b, diff;
`ifdef CLA_SUB_FLAGS_EN
    logic        zero, ovf;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        z;
        logic        o;
    } res_t;

    res_t expq[$];
    bit   m_busy = 0;
    int   m_cyc  = 0;

    cla_sub_serial #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef CLA_SUB_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the whole operands.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
        int   u, sx, sy, s;
        res_t r;
        u    = int'(x) - int'(y) - int'(c);
        r.d  = u[15:0];
        r.bo = (u < 0);
        r.z  = (r.d == 16'h0);
        sx   = $signed(x);
        sy   = $signed(y);
        s    = sx - sy - int'(c);
        r.o  = (s > 32767) || (s < -32768);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycle-level monitor. It compares every output against the model on every negedge.
    always @(negedge clk) begin
        res_t e;
        bit   ev;
        if (!rst_n) begin
            chk("rst_in_ready", 32'(in_ready), 1);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_diff", 32'(diff), 0);
            chk("rst_bout", 32'(bout), 0);
`ifdef CLA_SUB_FLAGS_EN
            chk("rst_zero", 32'(zero), 0);
            chk("rst_ovf", 32'(ovf), 0);
`endif
            m_busy = 0;
            m_cyc  = 0;
            expq.delete();
        end else begin
            ev = m_busy && (m_cyc >= NSLICE);
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("out_valid", 32'(out_valid), 32'(ev));
            if (ev) begin
                e = expq[0];
                chk("diff", 32'(diff), 32'(e.d));
                chk("bout", 32'(bout), 32'(e.bo));
`ifdef CLA_SUB_FLAGS_EN
                chk("zero", 32'(zero), 32'(e.z));
                chk("ovf", 32'(ovf), 32'(e.o));
`endif
            end
            if (!m_busy) begin
                if (in_valid) begin
                    expq.push_back(model(a, b, bin));
                    m_busy = 1;
                    m_cyc  = 0;
                end
            end else if (ev && out_ready) begin
                m_busy = 0;
                void'(expq.pop_front());
            end else begin
                m_cyc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c);
        int n;
        bit rdy;
        n = 0;
        a = x; b = y; bin = c; in_valid = 1;
        do begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        in_valid = 0;
        chk("send_accept", 32'(rdy), 1);
    endtask

    // Returns at the negedge where out_valid is first seen.
    task automatic wait_valid();
        int n;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        chk("latency", n, NSLICE);
    endtask

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                          input logic [15:0] ed, input logic ebo, input logic ez, input logic eo);
        send(x, y, c);
        wait_valid();
        chk("lit_diff", 32'(diff), 32'(ed));
        chk("lit_bout", 32'(bout), 32'(ebo));
`ifdef CLA_SUB_FLAGS_EN
        chk("lit_zero", 32'(zero), 32'(ez));
        chk("lit_ovf", 32'(ovf), 32'(eo));
`else
        if (ez && eo) $display("note: flags disabled");
`endif
        tick();
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 0; in_valid = 0; out_ready = 1; a = 0; b = 0; bin = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Pin the model itself to hand-computed values.
        chk("model_a", 32'(model(16'h1234, 16'h0034, 1'b0)), 32'({16'h1200, 1'b0, 1'b0, 1'b0}));
        chk("model_b", 32'(model(16'h0000, 16'h0001, 1'b0)), 32'({16'hFFFF, 1'b1, 1'b0, 1'b0}));
        chk("model_c", 32'(model(16'h8000, 16'h0000, 1'b1)), 32'({16'h7FFF, 1'b0, 1'b0, 1'b1}));
        chk("model_d", 32'(model(16'h5A5A, 16'h5A5A, 1'b0)), 32'({16'h0000, 1'b0, 1'b1, 1'b0}));

        run_op(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        run_op(16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Back-pressure with new operands offered while DONE.
        out_ready = 0;
        send(16'h1234, 16'h0034, 1'b0);
        wait_valid();
        tick();
        a = 16'hBEEF; b = 16'h1111; bin = 1; in_valid = 1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_diff", 32'(diff), 32'h1200);
            chk("bp_bout", 32'(bout), 0);
            tick();
        end
        out_ready = 1;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("bp_in_ready_back", 32'(in_ready), 1);
        tick();

        // Reset during the second RUN cycle.
        send(16'hFFFF, 16'h0001, 1'b0);
        tick();
        rst_n = 0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_diff", 32'(diff), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        tick();
        tick();
        rst_n = 1;
        repeat (6) tick();
        run_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

        // Random traffic with random back-pressure.
        repeat (600) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            a         = pick();
            b         = pick();
            bin       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 0;
        out_ready = 1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
